// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the regfile_sb slice.
//   clog2()      address width derivation
//   cnt_max()    saturation value of a CW-bit pending counter
//   XLEN_D, NREG_D, NRP_D, CW_D  default parameter values
//   CNT_MAX_D    counter maximum for the default CW
package regfile_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int cnt_max(input int cw);
    return (1 << cw) - 1;
  endfunction

  localparam int XLEN_D    = 32;
  localparam int NREG_D    = 32;
  localparam int NRP_D     = 2;
  localparam int CW_D      = 2;
  localparam int CNT_MAX_D = cnt_max(CW_D);

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundle of read, issue, writeback and squash signals
// between the ID stage (master) and the register file/scoreboard (slave).
//   raddr/ruse -> rdata/rbusy/stall : operand reads and hazard status
//   iss_valid/iss_rd -> iss_ready    : destination reservation
//   wb_valid/wb_rd/wb_data           : writeback
//   sq_valid/sq_rd                   : squash of one pending write
//   err                              : sticky counter error
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
);
  logic [NRP-1:0][AW-1:0]   raddr;
  logic [NRP-1:0]           ruse;
  logic [NRP-1:0][XLEN-1:0] rdata;
  logic [NRP-1:0]           rbusy;
  logic                     stall;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic                     wb_valid;
  logic [AW-1:0]            wb_rd;
  logic [XLEN-1:0]          wb_data;
  logic                     sq_valid;
  logic [AW-1:0]            sq_rd;
  logic                     err;

  modport master (
    output raddr, ruse, iss_valid, iss_rd, wb_valid, wb_rd, wb_data, sq_valid, sq_rd,
    input  rdata, rbusy, stall, iss_ready, err
  );

  modport slave (
    input  raddr, ruse, iss_valid, iss_rd, wb_valid, wb_rd, wb_data, sq_valid, sq_rd,
    output rdata, rbusy, stall, iss_ready, err
  );
endinterface

// File: rtl/sb_counter.sv
// sb_counter: pending-write counter for one register.
//   inc      one new in-flight write (0..1)
//   dec      retired writes this cycle (0..2: writeback and squash)
//   cnt      registered count
//   err      combinational pulse on underflow or overflow this cycle
// Underflow clamps to 0; overflow clamps to the maximum.
module sb_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [1:0]    dec,
  output logic [CW-1:0] cnt,
  output logic          err
);
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW:0]   sum, dec_x, diff;
  logic [CW-1:0] cnt_nxt;

  assign dec_x = (CW+1)'(dec);

  always_comb begin
    sum     = {1'b0, cnt} + (CW+1)'(inc);
    diff    = sum - dec_x;
    cnt_nxt = diff[CW-1:0];
    err     = 1'b0;
    if (dec_x > sum) begin
      cnt_nxt = '0;
      err     = 1'b1;
    end else if (diff > {1'b0, CMAX}) begin
      cnt_nxt = CMAX;
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: NREG x XLEN register file with NRP combinational read ports
// and a per-register pending-write scoreboard for the ID stage.
//   clk, rst  clock, asynchronous active-high reset
//   bus       regfile_sb_if slave: reads, issue, writeback, squash, err
// x0 reads zero, is never written, never counted and never busy.
// Optional macro REGFILE_BYPASS_EN: a read matching the current writeback
// returns wb_data and judges busy on the post-writeback count.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRP  = NRP_D,
  parameter int CW   = CW_D
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = clog2(NREG);
  localparam logic [CW-1:0] CMAX = CW'(cnt_max(CW));

  logic [NREG-1:0][XLEN-1:0] rf_v;
  logic [NREG-1:0][CW-1:0]   cnt_v;
  logic [NREG-1:0]           err_p;
  logic                      err_q;

  logic iss_fire, wb_hit, sq_hit;

  // ready looks only at the registered count, never at same-cycle retires
  assign bus.iss_ready = (cnt_v[bus.iss_rd] != CMAX) | (bus.iss_rd == '0);
  assign iss_fire = bus.iss_valid & bus.iss_ready & (bus.iss_rd != '0);
  assign wb_hit   = bus.wb_valid & (bus.wb_rd != '0);
  assign sq_hit   = bus.sq_valid & (bus.sq_rd != '0);

  assign rf_v[0]  = '0;
  assign cnt_v[0] = '0;
  assign err_p[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [XLEN-1:0] q;
    logic            w, s, i;
    logic [CW-1:0]   c;

    assign w = wb_hit & (bus.wb_rd == AW'(r));
    assign s = sq_hit & (bus.sq_rd == AW'(r));
    assign i = iss_fire & (bus.iss_rd == AW'(r));

    always_ff @(posedge clk or posedge rst)
      if (rst)    q <= '0;
      else if (w) q <= bus.wb_data;

    sb_counter #(.CW(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (i),
      .dec ({w & s, w ^ s}),
      .cnt (c),
      .err (err_p[r])
    );

    assign rf_v[r]  = q;
    assign cnt_v[r] = c;
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            busy;

    assign ra = bus.raddr[p];

    always_comb begin
      rd   = rf_v[ra];
      busy = cnt_v[ra] != '0;
`ifdef REGFILE_BYPASS_EN
      // ra != 0 is implied by wb_hit; busy after this writeback retires
      if (wb_hit && bus.wb_rd == ra) begin
        rd   = bus.wb_data;
        busy = cnt_v[ra] > CW'(1);
      end
`endif
    end

    assign bus.rdata[p] = rd;
    assign bus.rbusy[p] = busy;
  end

  assign bus.stall = |(bus.rbusy & bus.ruse);

  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | (|err_p);

  assign bus.err = err_q;

endmodule
